// File: rtl/wts_bank_mapper_if.sv
// MSX slot-side bus of the wave-table-sound MegaROM mapper.
// The CPU/slot side drives address, data and strobes; the mapper returns readback data.
interface wts_bank_mapper_if;
   logic [15:0] slot_a;
   logic [7:0]  slot_d_in;
   logic [7:0]  slot_d_out;
   logic        slot_d_oe;
   logic        slot_nsltsl;
   logic        slot_nmerq;
   logic        slot_nrd;
   logic        slot_nwr;

   modport master (
      output slot_a, slot_d_in, slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr,
      input  slot_d_out, slot_d_oe
   );

   modport slave (
      input  slot_a, slot_d_in, slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr,
      output slot_d_out, slot_d_oe
   );
endinterface

// File: rtl/wts_bank_mapper.sv
// Parametrised MegaROM bank mapper: 2..4 switchable 8 KB pages from 0x4000,
// synchronised slot strobes, one bank-register commit per write access, registered outputs.
module wts_bank_mapper #(
   parameter int BANK_COUNT = 4,
   parameter int BANK_BITS  = 8,
   parameter int READBACK   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   wts_bank_mapper_if.slave     slot,
   input  logic                 mapper_mode,
   output logic                 mem_ncs,
   output logic [BANK_BITS-1:0] mem_a,
   output logic                 reg_wr_pulse
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [2:0] PAGES    = 3'(BANK_COUNT);
   localparam logic       RB       = (READBACK != 0);

   function automatic logic [BANK_BITS-1:0] to_bank(input logic [7:0] d);
      logic [BANK_BITS-1:0] r;
      r = {BANK_BITS{1'b0}};
      for (int i = 0; i < BANK_BITS && i < 8; i++) r[i] = d[i];
      return r;
   endfunction

   function automatic logic [7:0] to_byte(input logic [BANK_BITS-1:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < BANK_BITS && i < 8; i++) r[i] = b[i];
      return r;
   endfunction

   // bit order {nsltsl, nmerq, nrd, nwr}
   logic [3:0]           sync1_r, sync2_r;
   logic [1:0]           fill_r;
   logic [1:0]           state_r, state_nxt_s;
   logic [BANK_BITS-1:0] bank_reg_r [BANK_COUNT];
   logic [BANK_BITS-1:0] eff_s;
   logic [2:0]           page_s;
   logic                 in_win_s, is_reg_s, fixed0_s;
   logic                 rd_q_s, wr_low_s, wr_high_s;
   logic                 rd_hit_s, drive_s, commit_s;
   logic                 unused_addr_s;

   assign page_s    = slot.slot_a[15:13] - 3'd2;
   assign in_win_s  = (page_s < PAGES);
   assign is_reg_s  = in_win_s && (slot.slot_a[12:11] == 2'b10);
   assign fixed0_s  = mapper_mode && (page_s == 3'd0);
   assign rd_q_s    = (sync2_r[3:1] == 3'b000);
   assign wr_low_s  = ({sync2_r[3:2], sync2_r[0]} == 3'b000);
   assign wr_high_s = ({sync2_r[3:2], sync2_r[0]} == 3'b111);
   assign rd_hit_s  = rd_q_s && in_win_s;
   assign drive_s   = rd_hit_s && is_reg_s && RB;
   assign commit_s  = (state_r == ST_ARMED) && wr_low_s && is_reg_s && !fixed0_s;
   assign unused_addr_s = ^slot.slot_a[10:0];

   // Effective bank of the addressed page, with page 0 pinned to bank 0 in fixed mode.
   always_comb begin
      eff_s = {BANK_BITS{1'b0}};
      for (int k = 0; k < BANK_COUNT; k++) begin
         eff_s = (page_s == 3'(k)) ? bank_reg_r[k] : eff_s;
      end
      eff_s = fixed0_s ? {BANK_BITS{1'b0}} : eff_s;
   end

   // Write detector next state; fill_r keeps it idle until the synchroniser holds real pin samples.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:  if (fill_r[1] && wr_high_s) state_nxt_s = ST_ARMED; else state_nxt_s = ST_IDLE;
         ST_ARMED: if (wr_low_s)               state_nxt_s = ST_DONE;  else state_nxt_s = ST_ARMED;
         ST_DONE:  if (!wr_low_s)              state_nxt_s = ST_ARMED; else state_nxt_s = ST_DONE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // Strobe synchronisers and pipeline-fill tracker.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= 4'b1111;
         sync2_r <= 4'b1111;
         fill_r  <= 2'b00;
      end else begin
         sync1_r <= {slot.slot_nsltsl, slot.slot_nmerq, slot.slot_nrd, slot.slot_nwr};
         sync2_r <= sync1_r;
         fill_r  <= {fill_r[0], 1'b1};
      end
   end

   // Bank registers, write FSM and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r         <= ST_IDLE;
         mem_ncs         <= 1'b1;
         mem_a           <= {BANK_BITS{1'b0}};
         reg_wr_pulse    <= 1'b0;
         slot.slot_d_oe  <= 1'b0;
         slot.slot_d_out <= 8'h00;
         for (int k = 0; k < BANK_COUNT; k++) bank_reg_r[k] <= BANK_BITS'(k);
      end else begin
         state_r         <= state_nxt_s;
         reg_wr_pulse    <= commit_s;
         mem_ncs         <= !(rd_hit_s && !drive_s);
         slot.slot_d_oe  <= drive_s;
         slot.slot_d_out <= drive_s ? to_byte(eff_s) : 8'h00;
         mem_a           <= in_win_s ? eff_s : mem_a;
         for (int k = 0; k < BANK_COUNT; k++) begin
            if (commit_s && (page_s == 3'(k))) bank_reg_r[k] <= to_bank(slot.slot_d_in);
         end
      end
   end
endmodule

// File: doc/wts_bank_mapper.md
# wts_bank_mapper

Parametrised MegaROM bank mapper for the wave-table-sound cartridge. It sits between the MSX slot bus and the external ROM/flash chip-select/high-address pins. It generalises the fixed two-bank cartridge mapper to 2–4 switchable 8 KB pages, a configurable bank-register width, a fixed-page-0 mode and optional bank-register readback. Slot strobes are synchronised into the `clk` domain. All outputs are registered.

## Interface
- `BANK_COUNT`, 4: number of 8 KB pages starting at 0x4000. Legal range 2..4, so the window is 0x4000 to 0x4000+BANK_COUNT*0x2000-1.
- `BANK_BITS`, 8: bank register width, which is also the `mem_a` width (8 gives 2 MB).
- `READBACK`, 0: 1 enables reads of bank-register addresses to return the register value.
- `clk` in 1: 21.47727 MHz system clock.
- `reset` in 1: asynchronous, active-high reset.
- `slot_a` in 16: slot address.
- `slot_d_in` in 8: slot data from the CPU.
- `slot_d_out` out 8: readback data.
- `slot_d_oe` out 1: readback drive enable. The top level builds the tristate.
- `slot_nsltsl`, `slot_nmerq`, `slot_nrd`, `slot_nwr` in 1 each: active-low slot strobes, asynchronous to `clk`.
- `mapper_mode` in 1: 0 selects all pages switchable; 1 fixes page 0 to bank 0.
- `mem_ncs` out 1: external memory chip select, active low.
- `mem_a` out BANK_BITS: external memory address bits [BANK_BITS+12:13].
- `reg_wr_pulse` out 1: one-clk pulse on every committed bank-register write.

## Operation
- **Reset values.** `mem_ncs`=1, `mem_a`=0, `slot_d_oe`=0, `slot_d_out`=0, `reg_wr_pulse`=0, `bank_reg[k]`=k (truncated to BANK_BITS). The write detector is disarmed.
- **Synchroniser.** Each of the four strobes passes through a 2-flop synchroniser. `slot_a` and `slot_d_in` are sampled in the clk where the synchronised strobes first qualify.
- **Page decode.** p = `slot_a[15:13]` - 2. The address is in the window when 0 ≤ p < BANK_COUNT. Addresses outside the window are ignored: no `mem_ncs`, no register write, no drive.
- **Register address.** In-window with `slot_a[12:11]`=2'b10, i.e. page base + 0x1000..0x17FF.
- **Write FSM.** States are IDLE, ARMED and DONE.
  - IDLE → ARMED when the synchronised `nsltsl`, `nmerq` and `nwr` are all high.
  - ARMED → DONE when the synchronised `nsltsl`, `nmerq` and `nwr` are all low.
  - On entering DONE at a register address: `bank_reg[p]` ← `slot_d_in[BANK_BITS-1:0]` and `reg_wr_pulse`=1 for one clk.
  - DONE → ARMED when any of those synchronised strobes rises.
  - Result: exactly one commit per access.
- **Writes to non-register addresses in the window.** No effect, and `mem_ncs` stays 1 (the memory is ROM).
- **`mapper_mode`=1.**
  - Writes to page-0's register are ignored, with no pulse and `bank_reg[0]` unchanged.
  - Page 0 presents bank 0 on `mem_a`.
  - Returning to mode 0 restores the stored `bank_reg[0]`.
- **Read, non-register address or READBACK=0.** `mem_ncs`=0 while the synchronised `nsltsl`, `nmerq` and `nrd` are all low and the address is in the window.
- **Read, register address with READBACK=1.**
  - `mem_ncs` stays 1.
  - `slot_d_oe`=1 and `slot_d_out` = zero-extended effective bank of page p for the same qualifying interval.
- **`mem_a`.** Registered every clk as the effective bank of `slot_a`'s page. Outside the window it holds its last value.

## Timing
- `mem_a` follows `slot_a` with 1 clk latency.
- `mem_ncs` and `slot_d_oe` assert 3 clks after the last of the qualifying strobes falls at the pins (2 synchroniser clks + 1 output register). They deassert 3 clks after the first strobe rises.
- Register commit and `reg_wr_pulse` occur 3 clks after the last of `nsltsl`/`nmerq`/`nwr` falls. The new value appears on `mem_a` 1 clk later.
- An assertion of `reset` mid-access clears all state immediately. After release with strobes still low, the FSM stays in IDLE: no commit for that access, and `mem_ncs` asserts normally if it is a read.
- A minimum strobe-low time of 4 clks (~190 ns) is guaranteed by Z80 timing. Shorter pulses may be missed.

## Test plan
- **Reset defaults.** Reset, then read 0x4000/0x6000/0x8000/0xA000 → `mem_a`=0,1,2,3 and `mem_ncs`=0 during each read.
- **Page write.** Write 0x5000=0x5A, then read 0x4001 → `mem_a`=0x5A, `mem_ncs`=0, `reg_wr_pulse` seen once. Write 0x4000=100 → no pulse, `mem_ncs`=1, `bank_reg` unchanged.
- **All banks.** Sweep i=0..255 step 3 on each page register (0x5000, 0x7000, 0x9000, 0xB000), reading page base+0 and base+1 → `mem_a`=i. Write 0xD000 → no pulse.
- **Fixed page 0.** With `mapper_mode`=1, write 0x5000=0x33 → no pulse, page-0 read gives `mem_a`=0. Set mode 0 → page-0 read gives the prior value.
- **Readback.** With READBACK=1 after writing 0x7000=0x81, read 0x7000 → `slot_d_oe`=1, `slot_d_out`=0x81, `mem_ncs`=1. With READBACK=0 the same read gives `slot_d_oe`=0 and `mem_ncs`=0.
- **Reset mid-write.** Assert `reset` during a 0x5000=0x77 write with `nwr` low, release before `nwr` rises → `bank_reg[0]`=0 and no pulse. The next full write to 0x5000 commits normally.
